// File: rtl/id_operand_stage.sv
// Decode / operand-fetch stage sitting in front of the 32x32 register file.
// Splits the IF/ID word, drives the file read ports, forwards same-cycle
// writeback, detects load-use hazards and registers everything into ID/EX.
module id_operand_stage #(
   parameter int XLEN      = 32,
   parameter int RADDR_W   = 5,
   parameter bit WB_BYPASS = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               if_valid,
   input  logic [31:0]        if_instr,
   input  logic [XLEN-1:0]    if_pc,
   input  logic               flush,
   output logic               id_stall,
   output logic [RADDR_W-1:0] rf_addr1,
   output logic [RADDR_W-1:0] rf_addr2,
   input  logic [XLEN-1:0]    rf_data1,
   input  logic [XLEN-1:0]    rf_data2,
   input  logic               wb_we,
   input  logic [RADDR_W-1:0] wb_addr,
   input  logic [XLEN-1:0]    wb_data,
   output logic               ex_valid,
   output logic [XLEN-1:0]    ex_pc,
   output logic [XLEN-1:0]    ex_rs_val,
   output logic [XLEN-1:0]    ex_rt_val,
   output logic [XLEN-1:0]    ex_imm,
   output logic [RADDR_W-1:0] ex_dest,
   output logic [5:0]         ex_funct,
   output logic [5:0]         ex_opcode,
   output logic               ex_reg_write,
   output logic               ex_mem_read,
   output logic               ex_mem_write,
   output logic               ex_branch
);

   typedef enum logic [5:0] {
      OP_RTYPE = 6'h00,
      OP_BEQ   = 6'h04,
      OP_ADDI  = 6'h08,
      OP_LW    = 6'h23,
      OP_SW    = 6'h2B
   } opcode_e;

   logic [RADDR_W-1:0] rs, rt;
   logic               use_rs, use_rt;
   logic               dec_rw, dec_mr, dec_mw, dec_br;
   logic [RADDR_W-1:0] dec_dest;
   logic [XLEN-1:0]    opnd1, opnd2;
   logic               hazard;

   logic               ex_valid_d,     ex_valid_q;
   logic [XLEN-1:0]    ex_pc_d,        ex_pc_q;
   logic [XLEN-1:0]    ex_rs_val_d,    ex_rs_val_q;
   logic [XLEN-1:0]    ex_rt_val_d,    ex_rt_val_q;
   logic [XLEN-1:0]    ex_imm_d,       ex_imm_q;
   logic [RADDR_W-1:0] ex_dest_d,      ex_dest_q;
   logic [5:0]         ex_funct_d,     ex_funct_q;
   logic [5:0]         ex_opcode_d,    ex_opcode_q;
   logic               ex_reg_write_d, ex_reg_write_q;
   logic               ex_mem_read_d,  ex_mem_read_q;
   logic               ex_mem_write_d, ex_mem_write_q;
   logic               ex_branch_d,    ex_branch_q;

   assign rs       = if_instr[25:21];
   assign rt       = if_instr[20:16];
   assign rf_addr1 = rs;
   assign rf_addr2 = rt;

   // Opcode decode: source usage, destination and control bits.
   always_comb begin
      use_rs   = 1'b0;
      use_rt   = 1'b0;
      dec_rw   = 1'b0;
      dec_mr   = 1'b0;
      dec_mw   = 1'b0;
      dec_br   = 1'b0;
      dec_dest = '0;
      case (if_instr[31:26])
         OP_RTYPE: begin
            use_rs = 1'b1; use_rt = 1'b1; dec_rw = 1'b1;
            dec_dest = if_instr[15:11];
         end
         OP_ADDI: begin
            use_rs = 1'b1; dec_rw = 1'b1;
            dec_dest = rt;
         end
         OP_LW: begin
            use_rs = 1'b1; dec_rw = 1'b1; dec_mr = 1'b1;
            dec_dest = rt;
         end
         OP_SW:   begin use_rs = 1'b1; use_rt = 1'b1; dec_mw = 1'b1; end
         OP_BEQ:  begin use_rs = 1'b1; use_rt = 1'b1; dec_br = 1'b1; end
         default: ;
      endcase
   end

   // Operand select: $0 reads as zero, else optional writeback forwarding.
   always_comb begin
      if (rs == '0)
         opnd1 = '0;
      else if (WB_BYPASS && wb_we && wb_addr != '0 && wb_addr == rs)
         opnd1 = wb_data;
      else
         opnd1 = rf_data1;
      if (rt == '0)
         opnd2 = '0;
      else if (WB_BYPASS && wb_we && wb_addr != '0 && wb_addr == rt)
         opnd2 = wb_data;
      else
         opnd2 = rf_data2;
   end

   // Load-use hazard against the instruction currently in EX.
   always_comb begin
      hazard = if_valid && ex_valid_q && ex_mem_read_q && (ex_dest_q != '0) &&
               ((use_rs && ex_dest_q == rs) || (use_rt && ex_dest_q == rt));
      id_stall = hazard && !flush;
   end

   // ID/EX next state; flush and bubble both clear valid and control.
   always_comb begin
      ex_pc_d        = if_pc;
      ex_rs_val_d    = opnd1;
      ex_rt_val_d    = opnd2;
      ex_imm_d       = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};
      ex_funct_d     = if_instr[5:0];
      ex_opcode_d    = if_instr[31:26];
      ex_valid_d     = if_valid;
      ex_reg_write_d = if_valid && dec_rw;
      ex_mem_read_d  = if_valid && dec_mr;
      ex_mem_write_d = if_valid && dec_mw;
      ex_branch_d    = if_valid && dec_br;
      if (flush || hazard) begin
         ex_valid_d     = 1'b0;
         ex_reg_write_d = 1'b0;
         ex_mem_read_d  = 1'b0;
         ex_mem_write_d = 1'b0;
         ex_branch_d    = 1'b0;
      end
      ex_dest_d = ex_reg_write_d ? dec_dest : '0;
   end

   // ID/EX pipeline register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q     <= 1'b0;
         ex_pc_q        <= '0;
         ex_rs_val_q    <= '0;
         ex_rt_val_q    <= '0;
         ex_imm_q       <= '0;
         ex_dest_q      <= '0;
         ex_funct_q     <= '0;
         ex_opcode_q    <= '0;
         ex_reg_write_q <= 1'b0;
         ex_mem_read_q  <= 1'b0;
         ex_mem_write_q <= 1'b0;
         ex_branch_q    <= 1'b0;
      end else begin
         ex_valid_q     <= ex_valid_d;
         ex_pc_q        <= ex_pc_d;
         ex_rs_val_q    <= ex_rs_val_d;
         ex_rt_val_q    <= ex_rt_val_d;
         ex_imm_q       <= ex_imm_d;
         ex_dest_q      <= ex_dest_d;
         ex_funct_q     <= ex_funct_d;
         ex_opcode_q    <= ex_opcode_d;
         ex_reg_write_q <= ex_reg_write_d;
         ex_mem_read_q  <= ex_mem_read_d;
         ex_mem_write_q <= ex_mem_write_d;
         ex_branch_q    <= ex_branch_d;
      end
   end

   assign ex_valid     = ex_valid_q;
   assign ex_pc        = ex_pc_q;
   assign ex_rs_val    = ex_rs_val_q;
   assign ex_rt_val    = ex_rt_val_q;
   assign ex_imm       = ex_imm_q;
   assign ex_dest      = ex_dest_q;
   assign ex_funct     = ex_funct_q;
   assign ex_opcode    = ex_opcode_q;
   assign ex_reg_write = ex_reg_write_q;
   assign ex_mem_read  = ex_mem_read_q;
   assign ex_mem_write = ex_mem_write_q;
   assign ex_branch    = ex_branch_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: decode table plus hand-written
// load-use, flush, reset and no-bypass sequences.
module tb_id_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        flush;
   logic [31:0] rf_data1, rf_data2;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   logic        id_stall, nb_id_stall;
   logic [4:0]  rf_addr1, rf_addr2, nb_rf_addr1, nb_rf_addr2;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
   logic [31:0] ex_pc, ex_rs_val, ex_rt_val, ex_imm;
   logic [4:0]  ex_dest;
   logic [5:0]  ex_funct, ex_opcode;
   logic        nb_valid, nb_rw, nb_mr, nb_mw, nb_br;
   logic [31:0] nb_pc, nb_rs_val, nb_rt_val, nb_imm;
   logic [4:0]  nb_dest;
   logic [5:0]  nb_funct, nb_opcode;

   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   id_operand_stage #(.XLEN(32), .RADDR_W(5), .WB_BYPASS(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
      .if_pc(if_pc), .flush(flush), .id_stall(id_stall),
      .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
      .rf_data1(rf_data1), .rf_data2(rf_data2),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_val(ex_rs_val),
      .ex_rt_val(ex_rt_val), .ex_imm(ex_imm), .ex_dest(ex_dest),
      .ex_funct(ex_funct), .ex_opcode(ex_opcode),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_branch(ex_branch)
   );

   id_operand_stage #(.XLEN(32), .RADDR_W(5), .WB_BYPASS(1'b0)) u_nb (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
      .if_pc(if_pc), .flush(flush), .id_stall(nb_id_stall),
      .rf_addr1(nb_rf_addr1), .rf_addr2(nb_rf_addr2),
      .rf_data1(rf_data1), .rf_data2(rf_data2),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_valid(nb_valid), .ex_pc(nb_pc), .ex_rs_val(nb_rs_val),
      .ex_rt_val(nb_rt_val), .ex_imm(nb_imm), .ex_dest(nb_dest),
      .ex_funct(nb_funct), .ex_opcode(nb_opcode),
      .ex_reg_write(nb_rw), .ex_mem_read(nb_mr),
      .ex_mem_write(nb_mw), .ex_branch(nb_br)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
      logic [31:0] rf1;
      logic [31:0] rf2;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        e_valid;
      logic [31:0] e_rs;
      logic [31:0] e_rt;
      logic [31:0] e_imm;
      logic [4:0]  e_dest;
      logic        e_rw;
      logic        e_mr;
      logic        e_mw;
      logic        e_br;
      logic        e_stall;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic valid,
                        input logic [31:0] d1, input logic [31:0] d2, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd);
      if_instr = instr; if_pc = pc; if_valid = valid;
      rf_data1 = d1; rf_data2 = d2;
      wb_we = we; wb_addr = wa; wb_data = wd;
   endtask

   task automatic chk_cleared(input string nm);
      chk({nm, ".valid"}, {31'd0, ex_valid}, 32'd0);
      chk({nm, ".pc"}, ex_pc, 32'd0);
      chk({nm, ".rs"}, ex_rs_val, 32'd0);
      chk({nm, ".rt"}, ex_rt_val, 32'd0);
      chk({nm, ".imm"}, ex_imm, 32'd0);
      chk({nm, ".dest"}, {27'd0, ex_dest}, 32'd0);
      chk({nm, ".ctl"}, {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, 32'd0);
      chk({nm, ".op"}, {20'd0, ex_opcode, ex_funct}, 32'd0);
   endtask

   initial begin
      vecs[0]  = '{32'h2023FFFC, 32'h100, 1'b1, 32'd10, 32'h77, 1'b0, 5'd0, 32'h0,
                   1'b1, 32'd10, 32'h77, 32'hFFFFFFFC, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{32'h00422020, 32'h104, 1'b1, 32'h11, 32'h11, 1'b1, 5'd2, 32'h55,
                   1'b1, 32'h55, 32'h55, 32'h2020, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{32'h8C250000, 32'h108, 1'b1, 32'h200, 32'h99, 1'b0, 5'd0, 32'h0,
                   1'b1, 32'h200, 32'h99, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{32'hAC220008, 32'h10C, 1'b1, 32'h300, 32'h44, 1'b0, 5'd0, 32'h0,
                   1'b1, 32'h300, 32'h44, 32'h8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{32'h1022FFFF, 32'h110, 1'b1, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0,
                   1'b1, 32'h1, 32'h2, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{32'hFC211234, 32'h114, 1'b1, 32'hA, 32'hB, 1'b0, 5'd0, 32'h0,
                   1'b1, 32'hA, 32'hB, 32'h1234, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{32'h00220020, 32'h118, 1'b1, 32'h3, 32'h4, 1'b0, 5'd0, 32'h0,
                   1'b1, 32'h3, 32'h4, 32'h20, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{32'h00003820, 32'h11C, 1'b1, 32'hDEAD, 32'hDEAD, 1'b1, 5'd0, 32'h1234,
                   1'b1, 32'h0, 32'h0, 32'h3820, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{32'h2023FFFC, 32'h120, 1'b0, 32'h5, 32'h6, 1'b0, 5'd0, 32'h0,
                   1'b0, 32'h5, 32'h6, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{32'hAC220008, 32'h124, 1'b1, 32'h1, 32'h2, 1'b1, 5'd2, 32'hCAFE,
                   1'b1, 32'h1, 32'hCAFE, 32'h8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{32'h8C250000, 32'h128, 1'b1, 32'h7, 32'h8, 1'b0, 5'd0, 32'h0,
                   1'b1, 32'h7, 32'h8, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{32'h00A03020, 32'h12C, 1'b0, 32'h9, 32'hA, 1'b0, 5'd0, 32'h0,
                   1'b0, 32'h9, 32'h0, 32'h3020, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0;
      flush = 1'b0;
      drive(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
      repeat (2) @(posedge clk);
      #1 chk_cleared("reset");
      @(negedge clk) rst_n = 1'b1;

      // Decode table, ordered so no entry forms a load-use pair with its predecessor.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive(vecs[i].instr, vecs[i].pc, vecs[i].valid, vecs[i].rf1, vecs[i].rf2,
               vecs[i].we, vecs[i].waddr, vecs[i].wdata);
         #1;
         chk($sformatf("v%0d.stall", i), {31'd0, id_stall}, {31'd0, vecs[i].e_stall});
         chk($sformatf("v%0d.addr", i), {22'd0, rf_addr1, rf_addr2},
             {22'd0, vecs[i].instr[25:21], vecs[i].instr[20:16]});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d.valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].e_valid});
         chk($sformatf("v%0d.pc", i), ex_pc, vecs[i].pc);
         chk($sformatf("v%0d.rs", i), ex_rs_val, vecs[i].e_rs);
         chk($sformatf("v%0d.rt", i), ex_rt_val, vecs[i].e_rt);
         chk($sformatf("v%0d.imm", i), ex_imm, vecs[i].e_imm);
         chk($sformatf("v%0d.dest", i), {27'd0, ex_dest}, {27'd0, vecs[i].e_dest});
         chk($sformatf("v%0d.ctl", i),
             {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch},
             {28'd0, vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_br});
         chk($sformatf("v%0d.op", i), {20'd0, ex_opcode, ex_funct},
             {20'd0, vecs[i].instr[31:26], vecs[i].instr[5:0]});
      end

      // Bypass disabled: raw register-file data reaches EX.
      @(negedge clk);
      drive(32'h00422020, 32'h200, 1'b1, 32'h11, 32'h11, 1'b1, 5'd2, 32'h55);
      @(posedge clk); #1;
      chk("nobyp.rs", nb_rs_val, 32'h11);
      chk("nobyp.rt", nb_rt_val, 32'h11);
      chk("byp.rs", ex_rs_val, 32'h55);
      chk("byp.rt", ex_rt_val, 32'h55);

      // Load-use: lw $5 then add $6,$5,$0 -> one bubble, then add issues.
      @(negedge clk);
      drive(32'h8C250000, 32'h300, 1'b1, 32'h200, 32'h0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      drive(32'h00A03020, 32'h304, 1'b1, 32'h55, 32'h66, 1'b0, 5'd0, 32'h0);
      #1 chk("lu.stall1", {31'd0, id_stall}, 32'd1);
      @(posedge clk); #1;
      chk("lu.bubble_valid", {31'd0, ex_valid}, 32'd0);
      chk("lu.bubble_ctl", {23'd0, ex_dest, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, 32'd0);
      @(negedge clk); #1;
      chk("lu.stall2", {31'd0, id_stall}, 32'd0);
      @(posedge clk); #1;
      chk("lu.issue_valid", {31'd0, ex_valid}, 32'd1);
      chk("lu.issue_dest", {27'd0, ex_dest}, 32'd6);
      chk("lu.issue_rs", ex_rs_val, 32'h55);
      chk("lu.issue_pc", ex_pc, 32'h304);

      // lw then add $6,$0,$0 -> no stall.
      @(negedge clk);
      drive(32'h8C250000, 32'h310, 1'b1, 32'h200, 32'h0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      drive(32'h00003020, 32'h314, 1'b1, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0);
      #1 chk("nolu.stall", {31'd0, id_stall}, 32'd0);
      @(posedge clk); #1;
      chk("nolu.valid", {31'd0, ex_valid}, 32'd1);
      chk("nolu.dest", {27'd0, ex_dest}, 32'd6);

      // Flush while the load-use pair is present.
      @(negedge clk);
      drive(32'h8C250000, 32'h320, 1'b1, 32'h200, 32'h0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      drive(32'h00A03020, 32'h324, 1'b1, 32'h55, 32'h66, 1'b0, 5'd0, 32'h0);
      flush = 1'b1;
      #1 chk("fl.stall", {31'd0, id_stall}, 32'd0);
      @(posedge clk); #1;
      chk("fl.valid", {31'd0, ex_valid}, 32'd0);
      chk("fl.ctl", {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, 1'b0}, 32'd0);
      @(negedge clk) flush = 1'b0;

      // Async reset mid-run, no clock edge needed.
      drive(32'h2023FFFC, 32'h400, 1'b1, 32'd10, 32'h77, 1'b0, 5'd0, 32'h0);
      @(posedge clk); #1;
      chk("pre_rst.valid", {31'd0, ex_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1 chk_cleared("async_rst");
      @(negedge clk) rst_n = 1'b1;

      // Reset asserted while stalled: next cycle decodes normally.
      @(negedge clk);
      drive(32'h8C250000, 32'h500, 1'b1, 32'h200, 32'h0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      drive(32'h00A03020, 32'h504, 1'b1, 32'h55, 32'h66, 1'b0, 5'd0, 32'h0);
      #1 chk("rst_stall.pre", {31'd0, id_stall}, 32'd1);
      rst_n = 1'b0;
      #1 chk("rst_stall.cleared", {31'd0, id_stall}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_stall.valid", {31'd0, ex_valid}, 32'd1);
      chk("rst_stall.dest", {27'd0, ex_dest}, 32'd6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
